// File: rtl/midi_rx_parser.sv
// MIDI serial receiver: 2-FF synchroniser, 8N1 UART and a channel-voice parser
// with running status that emits single-cycle note-on/note-off events.
module midi_rx_parser #(
  parameter int          CLK_FREQ_HZ = 50000000,
  parameter int          BAUD        = 31250,
  parameter int          OMNI        = 1,
  parameter logic [3:0]  CHANNEL     = 4'd0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       midi_port,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       framing_err,
  output logic       note_valid,
  output logic       note_on,
  output logic [6:0] note_num,
  output logic [6:0] velocity,
  output logic [3:0] channel
);

  localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;
  localparam int HALF         = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_END = CNT_W'(HALF - 1);

  typedef enum logic [2:0] {
    IDLE, START, DATA, STOP, WAIT_HIGH
  } uart_state_t;

  logic              sync1_q, rx_s_q;
  uart_state_t       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [7:0]        shift_q, shift_d;
  logic              byte_valid_q, byte_valid_d;
  logic [7:0]        byte_data_q, byte_data_d;
  logic              framing_err_q, framing_err_d;

  logic [7:0]        status_q, status_d;
  logic              count_q, count_d;
  logic [6:0]        d1_q, d1_d;
  logic              note_valid_q, note_valid_d;
  logic              note_on_q, note_on_d;
  logic [6:0]        note_num_q, note_num_d;
  logic [6:0]        velocity_q, velocity_d;
  logic [3:0]        channel_q, channel_d;
  logic              one_data_byte;
  logic              chan_pass;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q       <= 1'b1;
      rx_s_q        <= 1'b1;
      state_q       <= IDLE;
      cnt_q         <= '0;
      bit_idx_q     <= '0;
      shift_q       <= '0;
      byte_valid_q  <= 1'b0;
      byte_data_q   <= '0;
      framing_err_q <= 1'b0;
      status_q      <= '0;
      count_q       <= 1'b0;
      d1_q          <= '0;
      note_valid_q  <= 1'b0;
      note_on_q     <= 1'b0;
      note_num_q    <= '0;
      velocity_q    <= '0;
      channel_q     <= '0;
    end else begin
      sync1_q       <= midi_port;
      rx_s_q        <= sync1_q;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bit_idx_q     <= bit_idx_d;
      shift_q       <= shift_d;
      byte_valid_q  <= byte_valid_d;
      byte_data_q   <= byte_data_d;
      framing_err_q <= framing_err_d;
      status_q      <= status_d;
      count_q       <= count_d;
      d1_q          <= d1_d;
      note_valid_q  <= note_valid_d;
      note_on_q     <= note_on_d;
      note_num_q    <= note_num_d;
      velocity_q    <= velocity_d;
      channel_q     <= channel_d;
    end
  end

  // UART: sample mid-bit, LSB first
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    bit_idx_d     = bit_idx_q;
    shift_d       = shift_q;
    byte_valid_d  = 1'b0;
    byte_data_d   = byte_data_q;
    framing_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s_q) state_d = START;
      end
      START: begin
        if (cnt_q == HALF_END) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = rx_s_q ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt_q == BIT_END) begin
          cnt_d     = '0;
          shift_d   = {rx_s_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STOP: begin
        if (cnt_q == BIT_END) begin
          cnt_d = '0;
          if (rx_s_q) begin
            byte_data_d  = shift_q;
            byte_valid_d = 1'b1;
            state_d      = IDLE;
          end else begin
            framing_err_d = 1'b1;
            state_d       = WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WAIT_HIGH: begin
        cnt_d = '0;
        if (rx_s_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign one_data_byte = (status_q[7:4] == 4'hC) || (status_q[7:4] == 4'hD);
  assign chan_pass     = (OMNI != 0) || (status_q[3:0] == CHANNEL);

  // Parser: status_q[7] doubles as the "running status valid" flag
  always_comb begin
    status_d     = status_q;
    count_d      = count_q;
    d1_d         = d1_q;
    note_valid_d = 1'b0;
    note_on_d    = note_on_q;
    note_num_d   = note_num_q;
    velocity_d   = velocity_q;
    channel_d    = channel_q;
    if (byte_valid_q) begin
      if (byte_data_q >= 8'hF8) begin
        status_d = status_q;
      end else if (byte_data_q >= 8'hF0) begin
        status_d = '0;
        count_d  = 1'b0;
      end else if (byte_data_q[7]) begin
        status_d = byte_data_q;
        count_d  = 1'b0;
      end else if (status_q[7]) begin
        if (one_data_byte) begin
          d1_d    = byte_data_q[6:0];
          count_d = 1'b0;
        end else if (!count_q) begin
          d1_d    = byte_data_q[6:0];
          count_d = 1'b1;
        end else begin
          count_d = 1'b0;
          if ((status_q[7:5] == 3'b100) && chan_pass) begin
            note_valid_d = 1'b1;
            note_on_d    = status_q[4] && (byte_data_q[6:0] != 7'd0);
            note_num_d   = d1_q;
            velocity_d   = byte_data_q[6:0];
            channel_d    = status_q[3:0];
          end
        end
      end
    end
  end

  assign byte_valid  = byte_valid_q;
  assign byte_data   = byte_data_q;
  assign framing_err = framing_err_q;
  assign note_valid  = note_valid_q;
  assign note_on     = note_on_q;
  assign note_num    = note_num_q;
  assign velocity    = velocity_q;
  assign channel     = channel_q;

endmodule

// File: tb/tb_midi_rx_parser.sv
// Scoreboard bench for midi_rx_parser: two instances (omni, and channel-2 only)
// run at 16 clocks per bit; a monitor pops expected bytes/events as they appear.
module tb_midi_rx_parser;

  localparam int CPB = 16;

  logic clk = 1'b0;
  logic rst;
  logic rx0, rx1;

  logic       bv0, fe0, nv0, non0;
  logic [7:0] bd0;
  logic [6:0] nn0, vel0;
  logic [3:0] ch0;
  logic       bv1, fe1, nv1, non1;
  logic [7:0] bd1;
  logic [6:0] nn1, vel1;
  logic [3:0] ch1;

  always #5 clk = ~clk;

  midi_rx_parser #(.CLK_FREQ_HZ(500000), .BAUD(31250), .OMNI(1), .CHANNEL(4'd0)) dut0 (
    .clk(clk), .reset(rst), .midi_port(rx0),
    .byte_valid(bv0), .byte_data(bd0), .framing_err(fe0),
    .note_valid(nv0), .note_on(non0), .note_num(nn0), .velocity(vel0), .channel(ch0)
  );

  midi_rx_parser #(.CLK_FREQ_HZ(500000), .BAUD(31250), .OMNI(0), .CHANNEL(4'd2)) dut1 (
    .clk(clk), .reset(rst), .midi_port(rx1),
    .byte_valid(bv1), .byte_data(bd1), .framing_err(fe1),
    .note_valid(nv1), .note_on(non1), .note_num(nn1), .velocity(vel1), .channel(ch1)
  );

  int cmp_cnt = 0;
  int err_cnt = 0;

  // event word: {note_on, note_num, velocity, channel}
  logic [7:0]  byte_q0[$], byte_q1[$];
  logic [18:0] ev_q0[$],   ev_q1[$];
  int          fe_exp0 = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  always @(negedge clk) begin
    if (bv0 || fe0) check("excl0", 32'(bv0 & fe0), 32'd0);
    if (bv0) begin
      if (byte_q0.size() == 0) check("byte0_unexpected", 32'(bd0), 32'hFFFF_FFFF);
      else check("byte0", 32'(bd0), 32'(byte_q0.pop_front()));
    end
    if (fe0) begin
      check("ferr0", 32'(fe_exp0 > 0), 32'd1);
      if (fe_exp0 > 0) fe_exp0--;
    end
    if (nv0) begin
      if (ev_q0.size() == 0) check("event0_unexpected", 32'({non0, nn0, vel0, ch0}), 32'hFFFF_FFFF);
      else check("event0", 32'({non0, nn0, vel0, ch0}), 32'(ev_q0.pop_front()));
    end
    if (fe1) check("ferr1_unexpected", 32'(fe1), 32'd0);
    if (bv1) begin
      if (byte_q1.size() == 0) check("byte1_unexpected", 32'(bd1), 32'hFFFF_FFFF);
      else check("byte1", 32'(bd1), 32'(byte_q1.pop_front()));
    end
    if (nv1) begin
      if (ev_q1.size() == 0) check("event1_unexpected", 32'({non1, nn1, vel1, ch1}), 32'hFFFF_FFFF);
      else check("event1", 32'({non1, nn1, vel1, ch1}), 32'(ev_q1.pop_front()));
    end
  end

  task automatic drive(input int which, input logic v, input int cycles);
    if (which == 0) rx0 = v; else rx1 = v;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic send_byte(input int which, input logic [7:0] b, input logic stop);
    drive(which, 1'b0, CPB);
    for (int i = 0; i < 8; i++) drive(which, b[i], CPB);
    drive(which, stop, CPB);
    if (which == 0) rx0 = 1'b1; else rx1 = 1'b1;
  endtask

  task automatic send_good(input int which, input logic [7:0] b);
    if (which == 0) byte_q0.push_back(b); else byte_q1.push_back(b);
    send_byte(which, b, 1'b1);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_byte_valid"}, 32'(bv0), 32'd0);
    check({tag, "_byte_data"},  32'(bd0), 32'd0);
    check({tag, "_framing"},    32'(fe0), 32'd0);
    check({tag, "_note_valid"}, 32'(nv0), 32'd0);
    check({tag, "_note_on"},    32'(non0), 32'd0);
    check({tag, "_note_num"},   32'(nn0), 32'd0);
    check({tag, "_velocity"},   32'(vel0), 32'd0);
    check({tag, "_channel"},    32'(ch0), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    rx0 = 1'b1;
    rx1 = 1'b1;
    repeat (4) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // basic note-on
    ev_q0.push_back({1'b1, 7'd60, 7'd100, 4'd0});
    send_good(0, 8'h90); send_good(0, 8'h3C); send_good(0, 8'h64);

    // running status on ch1
    ev_q0.push_back({1'b1, 7'd64, 7'd127, 4'd1});
    ev_q0.push_back({1'b0, 7'd64, 7'd0,   4'd1});
    send_good(0, 8'h91); send_good(0, 8'h40); send_good(0, 8'h7F);
    send_good(0, 8'h40); send_good(0, 8'h00);

    // real-time bytes interleaved inside a note-off
    ev_q0.push_back({1'b0, 7'd60, 7'd64, 4'd0});
    send_good(0, 8'h80); send_good(0, 8'hF8); send_good(0, 8'h3C);
    send_good(0, 8'hFE); send_good(0, 8'h40);

    // short low glitch on idle line, then a 9n with velocity 0
    drive(0, 1'b0, 4);
    drive(0, 1'b1, 3 * CPB);
    ev_q0.push_back({1'b0, 7'd60, 7'd0, 4'd0});
    send_good(0, 8'h90); send_good(0, 8'h3C); send_good(0, 8'h00);

    // framing error, then recovery
    fe_exp0++;
    send_byte(0, 8'h55, 1'b0);
    drive(0, 1'b1, 2 * CPB);
    ev_q0.push_back({1'b1, 7'd48, 7'd16, 4'd0});
    send_good(0, 8'h90); send_good(0, 8'h30); send_good(0, 8'h10);
    repeat (2 * CPB) @(negedge clk);

    // reset during bit 4 of a note-on status byte
    drive(0, 1'b0, CPB);
    for (int i = 0; i < 4; i++) drive(0, 1'(8'h90 >> i), CPB);
    drive(0, 1'b1, CPB / 2);
    rst = 1'b1;
    @(negedge clk);
    check_zero("midreset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10 * CPB) @(negedge clk);
    // running status was cleared: these data bytes must not produce an event
    send_good(0, 8'h3C); send_good(0, 8'h40);

    // channel filter on the channel-2 instance
    ev_q1.push_back({1'b1, 7'd60, 7'd64, 4'd2});
    send_good(1, 8'h93); send_good(1, 8'h3C); send_good(1, 8'h40);
    send_good(1, 8'h92); send_good(1, 8'h3C); send_good(1, 8'h40);

    repeat (4 * CPB) @(negedge clk);
    check("left_bytes0",  32'(byte_q0.size()), 32'd0);
    check("left_events0", 32'(ev_q0.size()),   32'd0);
    check("left_ferr0",   32'(fe_exp0),        32'd0);
    check("left_bytes1",  32'(byte_q1.size()), 32'd0);
    check("left_events1", 32'(ev_q1.size()),   32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
